// File: rtl/izh_neuron_array.sv
// Time-multiplexed array of N Izhikevich neurons. One signed multiplier is
// shared by all neurons. Each start pulse advances every neuron by one Euler
// step and then publishes the spike vector for that sweep.
module izh_neuron_array #(
   parameter int W        = 20,
   parameter int F        = 16,
   parameter int N        = 8,
   parameter int DT_SHIFT = 4,
   localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [N*W-1:0]  i_bus,
   input  logic [W-1:0]    peak,
   input  logic            cfg_we,
   input  logic [IW-1:0]   cfg_idx,
   input  logic [1:0]      cfg_mode,
   input  logic [IW-1:0]   rd_idx,
   output logic [W-1:0]    rd_v,
   output logic [W-1:0]    rd_u,
   output logic            busy,
   output logic            done,
   output logic [N-1:0]    spike_vec
);

   typedef enum logic [2:0] {IDLE, LOAD, MUL_VV, MUL_BV, MUL_AU, WRITE, FIN} state_t;
   typedef enum logic [1:0] {RS, IB, CH, FS} mode_t;

   // Fixed-point constant from hundredths, rounded to the nearest LSB.
   function automatic logic signed [W-1:0] fx(input int centi);
      longint mag;
      mag = ((longint'(centi < 0 ? -centi : centi) << F) + 50) / 100;
      return (centi < 0) ? W'(-mag) : W'(mag);
   endfunction

   localparam logic signed [W-1:0] V_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] V_MIN = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [W-1:0] V_RST = fx(-70);
   localparam logic signed [W-1:0] U_RST = fx(-14);
   localparam logic signed [W-1:0] C14   = fx(140);
   localparam logic signed [W-1:0] B_ALL = fx(20);
   localparam logic signed [W-1:0] A_STD = fx(2);
   localparam logic signed [W-1:0] A_FS  = fx(10);
   localparam logic signed [W-1:0] C_RS  = fx(-65);
   localparam logic signed [W-1:0] C_IB  = fx(-55);
   localparam logic signed [W-1:0] C_CH  = fx(-50);
   localparam logic signed [W-1:0] D_RS  = fx(8);
   localparam logic signed [W-1:0] D_IB  = fx(4);
   localparam logic signed [W-1:0] D_LO  = fx(2);
   localparam logic [IW-1:0]       K_LAST = IW'(N - 1);

   // Clamp a widened sum back into the W-bit range.
   function automatic logic signed [W-1:0] sat_e(input logic signed [W+3:0] x);
      if (x[W+3:W-1] == {5{x[W+3]}}) return x[W-1:0];
      return x[W+3] ? V_MIN : V_MAX;
   endfunction

   // Clamp a shifted product back into the W-bit range.
   function automatic logic signed [W-1:0] sat_p(input logic signed [2*W-1:0] x);
      if (x[2*W-1:W-1] == {(W+1){x[2*W-1]}}) return x[W-1:0];
      return x[2*W-1] ? V_MIN : V_MAX;
   endfunction

   state_t                state;
   logic [IW-1:0]         k;
   logic signed [W-1:0]   v_mem [N];
   logic signed [W-1:0]   u_mem [N];
   mode_t                 mode_mem [N];
   logic [N-1:0]          spk_acc, spk_next;

   logic signed [W-1:0]   lv, lu, li, la, lc, ld;
   logic signed [W-1:0]   vv_r, bv_r, au_r;
   logic signed [W-1:0]   pa, pc, pd;
   logic signed [W-1:0]   mul_a, mul_b, mul_r;
   logic signed [2*W-1:0] mul_p;
   logic signed [W+3:0]   vsum;
   logic signed [W-1:0]   v_new, u_new;
   logic                  spike;

   assign rd_v = v_mem[rd_idx];
   assign rd_u = u_mem[rd_idx];

   // Preset decode for the neuron currently being loaded.
   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      pa = A_STD;
      pc = C_RS;
      pd = D_RS;
      case (mode_mem[k])
         IB:      begin pc = C_IB; pd = D_IB; end
         CH:      begin pc = C_CH; pd = D_LO; end
         FS:      begin pa = A_FS; pd = D_LO; end
         default: ;
      endcase
   end

   // Shared multiplier: operand select by phase, floor-shift by F, saturate.
   always_comb begin
      mul_a = lv;
      mul_b = lv;
      case (state)
         MUL_BV:  mul_a = B_ALL;
         MUL_AU:  begin mul_a = la; mul_b = sat_e((W+4)'(bv_r) - (W+4)'(lu)); end
         default: ;
      endcase
      mul_p = (2*W)'(mul_a) * (2*W)'(mul_b);
      mul_r = sat_p(mul_p >>> F);
   end

   // Euler update or spike reset for the neuron in WRITE.
   always_comb begin
      spike = lv > $signed(peak);
      vsum  = (W+4)'(vv_r) + (W+4)'(lv) + ((W+4)'(lv) >>> 2) + ((W+4)'(C14) >>> 2)
            - ((W+4)'(lu) >>> 2) + ((W+4)'(li) >>> 2);
      v_new = sat_e((W+4)'(lv) + (vsum >>> 2));
      u_new = sat_e((W+4)'(lu) + ((W+4)'(au_r) >>> DT_SHIFT));
      if (spike) begin
         v_new = lc;
         u_new = sat_e((W+4)'(lu) + (W+4)'(ld));
      end
      spk_next    = spk_acc;
      spk_next[k] = spike;
   end

   // Datapath pipeline registers; no reset needed, they are always loaded before use.
   always_ff @(posedge clk) begin
      case (state)
         LOAD: begin
            lv <= v_mem[k];
            lu <= u_mem[k];
            li <= i_bus[int'(k)*W +: W];
            la <= pa;
            lc <= pc;
            ld <= pd;
         end
         MUL_VV:  vv_r <= mul_r;
         MUL_BV:  bv_r <= mul_r;
         MUL_AU:  au_r <= mul_r;
         default: ;
      endcase
   end

   // Sweep sequencer, neuron state RAM, preset RAM and spike outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the state RAM is part of the architectural reset, so it is built from flops.
         for (int j = 0; j < N; j++) begin
            v_mem[j]    <= V_RST;
            u_mem[j]    <= U_RST;
            mode_mem[j] <= RS;
         end
         state     <= IDLE;
         k         <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         spike_vec <= '0;
         spk_acc   <= '0;
      end else begin
         // NOTE: non-blocking here so every register samples pre-edge values.
         done <= 1'b0;
         if (cfg_we) mode_mem[cfg_idx] <= mode_t'(cfg_mode);
         case (state)
            IDLE: if (start) begin
               state <= LOAD;
               k     <= '0;
               busy  <= 1'b1;
            end
            LOAD:   state <= MUL_VV;
            MUL_VV: state <= MUL_BV;
            MUL_BV: state <= MUL_AU;
            MUL_AU: state <= WRITE;
            WRITE: begin
               v_mem[k] <= v_new;
               u_mem[k] <= u_new;
               spk_acc  <= spk_next;
               if (k == K_LAST) begin
                  state     <= FIN;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  spike_vec <= spk_next;
               end else begin
                  k     <= k + 1'b1;
                  state <= LOAD;
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_izh_neuron_array.sv
// Directed bench for izh_neuron_array: reset values, sweep timing, step
// response, spikes, preset selection, saturation and mid-sweep reset.
module tb_izh_neuron_array;

   localparam int W  = 20;
   localparam int N  = 8;
   localparam int IW = 3;

   localparam longint V_RST  = -45875;
   localparam longint U_RST  = -9175;
   localparam longint PEAK30 = 19661;
   localparam longint C_RS   = -42598;
   localparam longint C_CH   = -32768;
   localparam longint D_RS   = 5243;
   localparam longint I_ONE  = 65536;
   localparam longint I_TWO  = 131072;
   localparam longint VMAX   = 524287;
   localparam longint VMIN   = -524288;

   logic           clk = 1'b0;
   logic           reset, start, cfg_we;
   logic [N*W-1:0] i_bus;
   logic [W-1:0]   peak;
   logic [IW-1:0]  cfg_idx, rd_idx;
   logic [1:0]     cfg_mode;
   logic [W-1:0]   rd_v, rd_u;
   logic           busy, done;
   logic [N-1:0]   spike_vec;

   int n_tests = 0;
   int n_fail  = 0;

   longint   mv [N];
   longint   mu [N];
   longint   mi [N];
   int       mmode [N];
   longint   mpeak;
   logic [N-1:0] mspk;

   izh_neuron_array dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .i_bus     (i_bus),
      .peak      (peak),
      .cfg_we    (cfg_we),
      .cfg_idx   (cfg_idx),
      .cfg_mode  (cfg_mode),
      .rd_idx    (rd_idx),
      .rd_v      (rd_v),
      .rd_u      (rd_u),
      .busy      (busy),
      .done      (done),
      .spike_vec (spike_vec)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_tol(input string tag, input longint obs, input longint exp, input longint tol);
      n_tests++;
      assert (obs >= exp - tol && obs <= exp + tol) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
      end
   endtask

   function automatic longint sat(input longint x);
      if (x > VMAX) return VMAX;
      if (x < VMIN) return VMIN;
      return x;
   endfunction

   function automatic longint mulf(input longint a, input longint b);
      return sat((a * b) >>> 16);
   endfunction

   // Reference Euler step for all neurons, straight from the neuron equations.
   task automatic model_sweep();
      for (int j = 0; j < N; j++) begin
         longint a, c, d, v, u, s, bv, au;
         v = mv[j];
         u = mu[j];
         case (mmode[j])
            1:       begin a = 1311; c = -36045; d = 2621; end
            2:       begin a = 1311; c = -32768; d = 1311; end
            3:       begin a = 6554; c = -42598; d = 1311; end
            default: begin a = 1311; c = -42598; d = 5243; end
         endcase
         if (v > mpeak) begin
            mv[j]   = c;
            mu[j]   = sat(u + d);
            mspk[j] = 1'b1;
         end else begin
            s       = mulf(v, v) + v + (v >>> 2) + 22937 - (u >>> 2) + (mi[j] >>> 2);
            mv[j]   = sat(v + (s >>> 2));
            bv      = mulf(13107, v);
            au      = mulf(a, sat(bv - u));
            mu[j]   = sat(u + (au >>> 4));
            mspk[j] = 1'b0;
         end
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < N; j++) begin
         mv[j]    = V_RST;
         mu[j]    = U_RST;
         mmode[j] = 0;
      end
      mspk = '0;
   endtask

   task automatic drive_inputs();
      for (int j = 0; j < N; j++) i_bus[j*W +: W] = W'(mi[j]);
      peak = W'(mpeak);
   endtask

   task automatic compare_all(input string ctx);
      for (int j = 0; j < N; j++) begin
         rd_idx = IW'(j);
         #1;
         check($sformatf("%s v%0d", ctx, j), longint'($signed(rd_v)), mv[j]);
         check($sformatf("%s u%0d", ctx, j), longint'($signed(rd_u)), mu[j]);
      end
   endtask

   task automatic read_v(input int j, output longint v, output longint u);
      rd_idx = IW'(j);
      #1;
      v = longint'($signed(rd_v));
      u = longint'($signed(rd_u));
   endtask

   task automatic cfg_write(input int idx, input int mode);
      @(posedge clk); #1;
      cfg_we   = 1'b1;
      cfg_idx  = IW'(idx);
      cfg_mode = 2'(mode);
      @(posedge clk); #1;
      cfg_we   = 1'b0;
      mmode[idx] = mode;
   endtask

   // One full sweep with optional mid-sweep cfg write and stray start pulse.
   task automatic do_sweep(input string ctx, input int cfg_at, input int cidx, input int cmode,
                           input int start_at);
      int done_at, busy_cnt, done_cnt;
      drive_inputs();
      done_at  = -1;
      busy_cnt = 0;
      done_cnt = 0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= 50; i++) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = i;
         end
         cfg_we   = (i == cfg_at);
         cfg_idx  = IW'(cidx);
         cfg_mode = 2'(cmode);
         start    = (i == start_at);
         @(posedge clk); #1;
      end
      start  = 1'b0;
      cfg_we = 1'b0;
      model_sweep();
      if (cfg_at > 0) mmode[cidx] = cmode;
      check($sformatf("%s done_at", ctx), done_at, 41);
      check($sformatf("%s busy_cycles", ctx), busy_cnt, 40);
      check($sformatf("%s done_pulses", ctx), done_cnt, 1);
      check($sformatf("%s spike_vec", ctx), longint'(spike_vec), longint'(mspk));
      compare_all(ctx);
   endtask

   initial begin
      longint v, u, pre_u;
      bit     seen, seen2, seen5;
      int     busy_cnt, done_cnt;

      reset    = 1'b0;
      start    = 1'b0;
      cfg_we   = 1'b0;
      cfg_idx  = '0;
      cfg_mode = '0;
      rd_idx   = '0;
      mpeak    = PEAK30;
      for (int j = 0; j < N; j++) mi[j] = 0;
      drive_inputs();
      model_reset();
      #2 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state.
      check("rst busy", longint'(busy), 0);
      check("rst done", longint'(done), 0);
      check("rst spike_vec", longint'(spike_vec), 0);
      compare_all("rst");

      // Equilibrium: rest point barely moves.
      do_sweep("equil", 0, 0, 0, 0);
      for (int j = 0; j < N; j++) begin
         read_v(j, v, u);
         check_tol($sformatf("equil tol v%0d", j), v, V_RST, 2);
         check_tol($sformatf("equil tol u%0d", j), u, U_RST, 2);
      end

      // Step response of neuron 0 to I = 1.0.
      mi[0] = I_ONE;
      do_sweep("step", 0, 0, 0, 0);
      read_v(0, v, u);
      check_tol("step v0", v, -41779, 2);

      // Drive neuron 3 to spike, check reset values, then bit clears.
      mi[0] = 0;
      mi[3] = I_TWO;
      seen  = 1'b0;
      for (int s = 0; s < 60 && !seen; s++) begin
         pre_u = mu[3];
         do_sweep("spk3", 0, 0, 0, 0);
         if (spike_vec[3]) begin
            seen = 1'b1;
            read_v(3, v, u);
            check("spk3 v3 reset", v, C_RS);
            check("spk3 u3 plus d", u, sat(pre_u + D_RS));
         end
      end
      check("spk3 seen", longint'(seen), 1);
      do_sweep("spk3 next", 0, 0, 0, 0);
      check("spk3 bit cleared", longint'(spike_vec[3]), 0);

      // Preset select: FS on 2, CH on 5; mid-sweep write on loaded neuron 0.
      mi[3] = 0;
      mi[2] = I_TWO;
      mi[5] = I_TWO;
      cfg_write(2, 3);
      cfg_write(5, 2);
      do_sweep("mode midcfg", 10, 0, 3, 0);
      seen2 = 1'b0;
      seen5 = 1'b0;
      for (int s = 0; s < 60 && !(seen2 && seen5); s++) begin
         do_sweep("mode", 0, 0, 0, 0);
         if (spike_vec[2] && !seen2) begin
            seen2 = 1'b1;
            read_v(2, v, u);
            check("mode FS v2 reset", v, C_RS);
         end
         if (spike_vec[5] && !seen5) begin
            seen5 = 1'b1;
            read_v(5, v, u);
            check("mode CH v5 reset", v, C_CH);
         end
      end
      check("mode seen2", longint'(seen2), 1);
      check("mode seen5", longint'(seen5), 1);

      // Saturation with a stray start while busy, then a normal follow-up.
      for (int j = 0; j < N; j++) mi[j] = 0;
      mi[0] = VMAX;
      mpeak = VMAX;
      do_sweep("sat busy_start", 0, 0, 0, 20);
      for (int s = 0; s < 30 && mv[0] != VMAX; s++) do_sweep("sat", 0, 0, 0, 0);
      do_sweep("sat hold", 0, 0, 0, 0);
      read_v(0, v, u);
      check("sat v0 clamp", v, VMAX);

      // Asynchronous reset at cycle 17 of a sweep.
      mpeak = PEAK30;
      mi[0] = 0;
      drive_inputs();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (16) begin @(posedge clk); #1; end
      reset = 1'b1;
      #1;
      check("arst busy", longint'(busy), 0);
      check("arst done", longint'(done), 0);
      check("arst spike_vec", longint'(spike_vec), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      compare_all("arst");
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (busy) busy_cnt++;
         if (done) done_cnt++;
      end
      check("arst no busy", busy_cnt, 0);
      check("arst no done", done_cnt, 0);

      // Modes back to RS: neuron 5 must now reset to RS c.
      mi[2] = I_TWO;
      mi[5] = I_TWO;
      seen5 = 1'b0;
      for (int s = 0; s < 60 && !seen5; s++) begin
         do_sweep("arst mode", 0, 0, 0, 0);
         if (spike_vec[5]) begin
            seen5 = 1'b1;
            read_v(5, v, u);
            check("arst v5 RS reset", v, C_RS);
         end
      end
      check("arst seen5", longint'(seen5), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/izh_neuron_array.md
Name: izh_neuron_array

Overview:
Parametrised, time-multiplexed array of N Izhikevich neurons. It shares one signed multiplier across all neurons. Each neuron holds its own v/u state and one of four selectable parameter presets. One `start` pulse performs one Euler step (dt = 2^-DT_SHIFT) for every neuron, then reports a spike vector. The block sits between the stimulus/current front end and the spike-event logic.

Parameters:
- W, 20, datapath width (signed two's complement)
- F, 16, fractional bits; value = integer/2^F
- N, 8, neuron count (>=1)
- DT_SHIFT, 4, time-step shift used in the u update

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a sweep over all N neurons
- i_bus  in  N*W  input currents, neuron k at [k*W +: W], sampled when neuron k is loaded
- peak  in  W  spike threshold p (signed)
- cfg_we  in  1  parameter-preset write strobe
- cfg_idx  in  clog2(N)  neuron index for cfg write
- cfg_mode  in  2  0=RS, 1=IB, 2=CH, 3=FS
- rd_idx  in  clog2(N)  readback index
- rd_v  out  W  v of neuron rd_idx (combinational from state RAM)
- rd_u  out  W  u of neuron rd_idx
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when the sweep completes
- spike_vec  out  N  bit k = neuron k spiked in the last sweep (held until next done)

Behaviour:
- Reset is asynchronous. All neurons: v = -0.70, u = -0.14, mode = RS. Outputs: busy=0, done=0, spike_vec=0, FSM in IDLE. Constants are rounded to the nearest LSB.
- Presets (a, b, c, d):
  - RS: 0.02, 0.2, -0.65, 0.08
  - IB: 0.02, 0.2, -0.55, 0.04
  - CH: 0.02, 0.2, -0.50, 0.02
  - FS: 0.10, 0.2, -0.65, 0.02
  - Constant C14 = 1.40.
- FSM states: IDLE -> LOAD -> MUL_VV -> MUL_BV -> MUL_AU -> WRITE -> (LOAD for next k | FIN) -> IDLE.
  - Each neuron takes exactly 5 cycles (LOAD..WRITE), independent of the spike outcome.
  - done is asserted 5N+1 cycles after the start edge, in FIN.
- LOAD: latches v, u, I_k, and the preset for neuron k. A cfg write landing during or after LOAD of neuron k takes effect on the next sweep.
- Multiply: full 2W-bit product, shifted right by F with arithmetic rounding toward -inf. The result saturates to [-2^(W-1), 2^(W-1)-1].
- Non-spike update (v <= peak). All sums are computed at W+4 bits and saturated to W on writeback.
  - v' = v + ((v*v + v + (v>>>2) + (C14>>>2) - (u>>>2) + (I>>>2)) >>> 2)
  - u' = u + ((a*(b*v - u)) >>> DT_SHIFT)
- Spike (v > peak, signed compare on the latched v): v' = c, u' = sat(u + d), spike bit k = 1. The multiplier results are discarded.
- spike_vec is accumulated internally and transferred to the output at done. It is not cleared at start.
- start while busy is ignored, not queued. start and done in the same cycle is impossible because done is issued from FIN, not IDLE. start in the IDLE cycle following FIN is accepted.
- cfg_we is accepted in any state. Simultaneous cfg_we to the same idx is impossible (single port).
- rd_idx readback is valid at any time. During a sweep it shows the committed state; neuron k's value changes at the WRITE edge.
- An asynchronous reset mid-sweep aborts immediately. All state and modes return to reset values, and no done is issued.
- N=1 is legal: the sweep is 6 cycles.

Test Plan:
- Reset equilibrium: reset, i_bus=0, peak=0.30, one start. Expect done at +41 cycles (N=8), spike_vec=0, and every rd_v = -0.70, rd_u = -0.14, each within ±2 LSB.
- Step response: I_0 = 1.0, others 0, one sweep. Expect rd_v[0] = -0.6375 ±2 LSB, other v unchanged, busy high for exactly 40 cycles.
- Spike and reset: I_3 = 2.0, peak = 0.30, repeat sweeps until spike_vec[3]=1. In that sweep's result, v3 = -0.65 and u3 = previous u3 + 0.08. On the next sweep, bit 3 clears.
- Mode select: cfg_mode=3 (FS) on neuron 2 and cfg_mode=2 (CH) on neuron 5, then drive to spike. Expect v2 reset to -0.65 and v5 reset to -0.50. A cfg write issued mid-sweep on an already-loaded neuron does not affect that sweep.
- Saturation and control: force v near +max via large I. Expect rd_v clamped at 2^(W-1)-1 with no wrap. A start pulse while busy changes nothing. A second start after done runs normally.
- Async reset mid-sweep: assert reset at cycle 17 of a sweep. Expect busy=0 immediately, no done, and all v/u/modes at reset values.
